// File: rtl/pipe_staller.sv
// Hazard and stall controller for the 5-stage pipeline: per-stage stall codes,
// PC redirects (deferred while a fetch is outstanding) and bring-up counters.
module pipe_staller #(
    parameter int unsigned CNT_W = 32
) (
    input  logic             dclk,
    input  logic             rst,
    input  logic             if_busy_i,
    input  logic             mem_busy_i,
    input  logic             ex_is_load_i,
    input  logic [4:0]       ex_rd_i,
    input  logic [4:0]       id_rs1_i,
    input  logic             id_rs1_used_i,
    input  logic [4:0]       id_rs2_i,
    input  logic             id_rs2_used_i,
    input  logic             ex_jump_i,
    input  logic [31:0]      ex_target_i,
    output logic             pc_wr_o,
    output logic [31:0]      pc_target_o,
    output logic [1:0]       stl_pc_o,
    output logic [1:0]       stl_if_id_o,
    output logic [1:0]       stl_id_ex_o,
    output logic [1:0]       stl_ex_mem_o,
    output logic [1:0]       stl_mem_wb_o,
    output logic [CNT_W-1:0] stall_cnt_o,
    output logic [CNT_W-1:0] flush_cnt_o
);

    localparam int unsigned ADDR_W = 32;

    localparam logic [1:0] GO     = 2'b00;
    localparam logic [1:0] STALL  = 2'b01;
    localparam logic [1:0] BUBBLE = 2'b10;

    typedef enum logic {
        RUN           = 1'b0,
        REDIRECT_WAIT = 1'b1
    } state_t;

    state_t              state, state_nx;
    logic [ADDR_W-1:0]   pend_target, pend_target_nx;
    logic                lu;
    logic                stall_inc;
    logic                flush_inc;

    // Load-use: ID reads the register the EX load is about to write
    assign lu = ex_is_load_i && (ex_rd_i != 5'd0) &&
                ((id_rs1_used_i && (id_rs1_i == ex_rd_i)) ||
                 (id_rs2_used_i && (id_rs2_i == ex_rd_i)));

    always_ff @(posedge dclk or negedge rst) begin
        if (!rst) begin
            state       <= RUN;
            pend_target <= '0;
        end else begin
            state       <= state_nx;
            pend_target <= pend_target_nx;
        end
    end

    always_comb begin
        state_nx       = state;
        pend_target_nx = pend_target;
        pc_wr_o        = 1'b0;
        pc_target_o    = '0;
        stl_pc_o       = GO;
        stl_if_id_o    = GO;
        stl_id_ex_o    = GO;
        stl_ex_mem_o   = GO;
        stl_mem_wb_o   = GO;

        if (!rst) begin
            stl_pc_o     = BUBBLE;
            stl_if_id_o  = BUBBLE;
            stl_id_ex_o  = BUBBLE;
            stl_ex_mem_o = BUBBLE;
            stl_mem_wb_o = BUBBLE;
        end else begin
            case (state)
                RUN: begin
                    if (mem_busy_i) begin
                        // EX is frozen, so a pending jump is still visible next cycle
                        stl_pc_o     = STALL;
                        stl_if_id_o  = STALL;
                        stl_id_ex_o  = STALL;
                        stl_ex_mem_o = STALL;
                        stl_mem_wb_o = BUBBLE;
                    end else if (ex_jump_i && !if_busy_i) begin
                        pc_wr_o     = 1'b1;
                        pc_target_o = ex_target_i;
                        stl_if_id_o = BUBBLE;
                        stl_id_ex_o = BUBBLE;
                    end else if (ex_jump_i) begin
                        pend_target_nx = ex_target_i;
                        state_nx       = REDIRECT_WAIT;
                        stl_pc_o       = STALL;
                        stl_if_id_o    = BUBBLE;
                        stl_id_ex_o    = BUBBLE;
                    end else if (lu) begin
                        stl_pc_o    = STALL;
                        stl_if_id_o = STALL;
                        stl_id_ex_o = BUBBLE;
                    end else if (if_busy_i) begin
                        stl_pc_o    = STALL;
                        stl_if_id_o = BUBBLE;
                    end
                end
                REDIRECT_WAIT: begin
                    if (mem_busy_i) begin
                        stl_pc_o     = STALL;
                        stl_if_id_o  = STALL;
                        stl_id_ex_o  = STALL;
                        stl_ex_mem_o = STALL;
                        stl_mem_wb_o = BUBBLE;
                    end else if (if_busy_i) begin
                        // Fetch in flight is wrong-path; drop it and keep waiting
                        stl_pc_o    = STALL;
                        stl_if_id_o = BUBBLE;
                        stl_id_ex_o = BUBBLE;
                    end else begin
                        pc_wr_o     = 1'b1;
                        pc_target_o = pend_target;
                        stl_if_id_o = BUBBLE;
                        stl_id_ex_o = BUBBLE;
                        state_nx    = RUN;
                    end
                end
                default: state_nx = RUN;
            endcase
        end
    end

    assign stall_inc = (stl_pc_o == STALL);
    assign flush_inc = pc_wr_o;

    // Saturating bring-up counters
    always_ff @(posedge dclk or negedge rst) begin
        if (!rst) begin
            stall_cnt_o <= '0;
            flush_cnt_o <= '0;
        end else begin
            if (stall_inc && (stall_cnt_o != '1)) begin
                stall_cnt_o <= stall_cnt_o + CNT_W'(1);
            end
            if (flush_inc && (flush_cnt_o != '1)) begin
                flush_cnt_o <= flush_cnt_o + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_pipe_staller.sv
// Directed bench for pipe_staller: a 32-bit-counter instance and a 4-bit-counter
// instance driven by the same stimulus, checked against hand-computed values.
module tb_pipe_staller;

    logic        dclk;
    logic        rst;
    logic        if_busy_i;
    logic        mem_busy_i;
    logic        ex_is_load_i;
    logic [4:0]  ex_rd_i;
    logic [4:0]  id_rs1_i;
    logic        id_rs1_used_i;
    logic [4:0]  id_rs2_i;
    logic        id_rs2_used_i;
    logic        ex_jump_i;
    logic [31:0] ex_target_i;

    logic        pc_wr, pc_wr4;
    logic [31:0] tgt, tgt4;
    logic [1:0]  s_pc, s_ifid, s_idex, s_exmem, s_memwb;
    logic [1:0]  t_pc, t_ifid, t_idex, t_exmem, t_memwb;
    logic [31:0] stall_cnt, flush_cnt;
    logic [3:0]  stall_cnt4, flush_cnt4;
    logic [9:0]  codes, codes4;

    int checks;
    int failures;

    assign codes  = {s_pc, s_ifid, s_idex, s_exmem, s_memwb};
    assign codes4 = {t_pc, t_ifid, t_idex, t_exmem, t_memwb};

    pipe_staller #(.CNT_W(32)) dut (
        .dclk(dclk), .rst(rst), .if_busy_i(if_busy_i), .mem_busy_i(mem_busy_i),
        .ex_is_load_i(ex_is_load_i), .ex_rd_i(ex_rd_i), .id_rs1_i(id_rs1_i),
        .id_rs1_used_i(id_rs1_used_i), .id_rs2_i(id_rs2_i), .id_rs2_used_i(id_rs2_used_i),
        .ex_jump_i(ex_jump_i), .ex_target_i(ex_target_i), .pc_wr_o(pc_wr),
        .pc_target_o(tgt), .stl_pc_o(s_pc), .stl_if_id_o(s_ifid), .stl_id_ex_o(s_idex),
        .stl_ex_mem_o(s_exmem), .stl_mem_wb_o(s_memwb), .stall_cnt_o(stall_cnt),
        .flush_cnt_o(flush_cnt)
    );

    pipe_staller #(.CNT_W(4)) dut4 (
        .dclk(dclk), .rst(rst), .if_busy_i(if_busy_i), .mem_busy_i(mem_busy_i),
        .ex_is_load_i(ex_is_load_i), .ex_rd_i(ex_rd_i), .id_rs1_i(id_rs1_i),
        .id_rs1_used_i(id_rs1_used_i), .id_rs2_i(id_rs2_i), .id_rs2_used_i(id_rs2_used_i),
        .ex_jump_i(ex_jump_i), .ex_target_i(ex_target_i), .pc_wr_o(pc_wr4),
        .pc_target_o(tgt4), .stl_pc_o(t_pc), .stl_if_id_o(t_ifid), .stl_id_ex_o(t_idex),
        .stl_ex_mem_o(t_exmem), .stl_mem_wb_o(t_memwb), .stall_cnt_o(stall_cnt4),
        .flush_cnt_o(flush_cnt4)
    );

    initial dclk = 1'b0;
    always #5 dclk = ~dclk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Codes packed as {pc, if_id, id_ex, ex_mem, mem_wb}
    task automatic chk_out(input string tag, input logic [9:0] exp_codes,
                           input logic exp_wr, input logic [31:0] exp_tgt);
        chk({tag, ".codes"},  32'(codes),  32'(exp_codes));
        chk({tag, ".wr"},     32'(pc_wr),  32'(exp_wr));
        chk({tag, ".tgt"},    tgt,         exp_tgt);
        chk({tag, ".codes4"}, 32'(codes4), 32'(exp_codes));
        chk({tag, ".wr4"},    32'(pc_wr4), 32'(exp_wr));
        chk({tag, ".tgt4"},   tgt4,        exp_tgt);
    endtask

    task automatic chk_cnt(input string tag, input int exp_stall, input int exp_flush);
        int s4;
        s4 = (exp_stall > 15) ? 15 : exp_stall;
        chk({tag, ".stall"},  stall_cnt,         32'(exp_stall));
        chk({tag, ".flush"},  flush_cnt,         32'(exp_flush));
        chk({tag, ".stall4"}, 32'(stall_cnt4),   32'(s4));
        chk({tag, ".flush4"}, 32'(flush_cnt4),   32'(exp_flush));
    endtask

    task automatic tick();
        @(posedge dclk);
        #1;
    endtask

    task automatic clear_inputs();
        if_busy_i = 0; mem_busy_i = 0; ex_is_load_i = 0; ex_rd_i = 0;
        id_rs1_i = 0; id_rs1_used_i = 0; id_rs2_i = 0; id_rs2_used_i = 0;
        ex_jump_i = 0; ex_target_i = 0;
    endtask

    task automatic set_lu();
        ex_is_load_i = 1; ex_rd_i = 5'd5; id_rs2_i = 5'd5; id_rs2_used_i = 1;
    endtask

    initial begin
        checks = 0;
        failures = 0;
        rst = 0;
        clear_inputs();

        // Reset held low
        #12;
        chk_out("reset", 10'b10_10_10_10_10, 0, 32'h0);
        chk_cnt("reset", 0, 0);
        tick();
        rst = 1;
        #1;
        chk_out("release", 10'b00_00_00_00_00, 0, 32'h0);
        tick();
        chk_cnt("idle", 0, 0);

        // Load-use via rs2
        set_lu();
        #1;
        chk_out("lu_rs2", 10'b01_01_10_00_00, 0, 32'h0);
        tick();
        chk_cnt("lu_rs2", 1, 0);

        // Same stimulus with x0 destination: no hazard
        ex_rd_i = 5'd0; id_rs2_i = 5'd0;
        #1;
        chk_out("lu_x0", 10'b00_00_00_00_00, 0, 32'h0);
        tick();
        chk_cnt("lu_x0", 1, 0);

        // Load-use via rs1; then rs1 matches but is unused
        clear_inputs();
        ex_is_load_i = 1; ex_rd_i = 5'd7; id_rs1_i = 5'd7; id_rs1_used_i = 1;
        #1;
        chk_out("lu_rs1", 10'b01_01_10_00_00, 0, 32'h0);
        tick();
        chk_cnt("lu_rs1", 2, 0);
        id_rs1_used_i = 0;
        #1;
        chk_out("lu_unused", 10'b00_00_00_00_00, 0, 32'h0);
        tick();

        // Immediate redirect
        clear_inputs();
        ex_jump_i = 1; ex_target_i = 32'h0000_0100;
        #1;
        chk_out("jump", 10'b00_10_10_00_00, 1, 32'h100);
        tick();
        chk_cnt("jump", 2, 1);

        // Redirect deferred by an outstanding fetch
        ex_target_i = 32'h0000_0200; if_busy_i = 1;
        #1;
        chk_out("jump_busy", 10'b01_10_10_00_00, 0, 32'h0);
        tick();
        chk_cnt("jump_busy", 3, 1);
        // In the wait, new jumps and load-use are ignored
        ex_target_i = 32'h0000_0300; set_lu();
        for (int i = 0; i < 3; i++) begin
            #1;
            chk_out("rw_wait", 10'b01_10_10_00_00, 0, 32'h0);
            tick();
        end
        chk_cnt("rw_wait", 6, 1);
        if_busy_i = 0;
        #1;
        chk_out("rw_fire", 10'b00_10_10_00_00, 1, 32'h200);
        tick();
        chk_cnt("rw_fire", 6, 2);
        clear_inputs();
        #1;
        chk_out("rw_back_run", 10'b00_00_00_00_00, 0, 32'h0);
        tick();

        // MEM stall dominates jump and load-use
        mem_busy_i = 1; ex_jump_i = 1; ex_target_i = 32'h0000_0400; set_lu();
        for (int i = 0; i < 4; i++) begin
            #1;
            chk_out("mem_busy", 10'b01_01_01_01_10, 0, 32'h0);
            tick();
        end
        chk_cnt("mem_busy", 10, 2);
        mem_busy_i = 0;
        #1;
        chk_out("mem_release", 10'b00_10_10_00_00, 1, 32'h400);
        tick();
        chk_cnt("mem_release", 10, 3);

        // Saturation of the 4-bit stall counter
        clear_inputs();
        mem_busy_i = 1;
        for (int i = 0; i < 6; i++) tick();
        chk_cnt("sat", 16, 3);
        tick();
        tick();
        chk_cnt("sat_hold", 18, 3);

        // MEM stall inside REDIRECT_WAIT keeps waiting
        clear_inputs();
        ex_jump_i = 1; ex_target_i = 32'h0000_0500; if_busy_i = 1;
        tick();
        ex_jump_i = 0; mem_busy_i = 1;
        #1;
        chk_out("rw_mem", 10'b01_01_01_01_10, 0, 32'h0);
        tick();
        mem_busy_i = 0;
        #1;
        chk_out("rw_still", 10'b01_10_10_00_00, 0, 32'h0);
        tick();
        chk_cnt("rw_still", 21, 3);

        // Reset aborts the pending redirect
        rst = 0;
        #1;
        chk_out("rst_pulse", 10'b10_10_10_10_10, 0, 32'h0);
        chk_cnt("rst_pulse", 0, 0);
        #2;
        rst = 1;
        if_busy_i = 0;
        #1;
        chk_out("post_rst", 10'b00_00_00_00_00, 0, 32'h0);
        tick();
        chk_out("post_rst2", 10'b00_00_00_00_00, 0, 32'h0);
        chk_cnt("post_rst", 0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/pipe_staller.md
Name: pipe_staller

Overview:
- Central hazard and stall controller for the 5-stage RISC-V pipeline (IF, ID, EX, MEM, WB).
- Each cycle it drives the 2-bit stall code of the PC register and of every inter-stage register (IF_ID, ID_EX, EX_MEM, MEM_WB).
- It also issues PC redirects for taken branches and jumps, deferring a redirect while an instruction fetch is outstanding.
- It keeps saturating counters of stall cycles and of redirects for FPGA bring-up.

Parameters:
- CNT_W, 32, width of stall_cnt_o and flush_cnt_o.

Ports:
- dclk  in  1  pipeline clock.
- rst  in  1  asynchronous, active-low reset.
- if_busy_i  in  1  IF fetch outstanding; the instruction at IF is not valid.
- mem_busy_i  in  1  MEM-stage data access outstanding.
- ex_is_load_i  in  1  EX holds a load.
- ex_rd_i  in  5  destination register of the EX instruction.
- id_rs1_i  in  5  rs1 of the ID instruction.
- id_rs1_used_i  in  1  ID instruction reads rs1.
- id_rs2_i  in  5  rs2 of the ID instruction.
- id_rs2_used_i  in  1  ID instruction reads rs2.
- ex_jump_i  in  1  EX resolved a taken branch or jump.
- ex_target_i  in  32  redirect target.
- pc_wr_o  out  1  load pc_target_o into the PC this cycle.
- pc_target_o  out  32  redirect address.
- stl_pc_o, stl_if_id_o, stl_id_ex_o, stl_ex_mem_o, stl_mem_wb_o  out  2 each  stall codes.
- stall_cnt_o  out  CNT_W  cycles with stl_pc_o == Stall.
- flush_cnt_o  out  CNT_W  redirects issued.

Behaviour:
- Stall codes come from the shared macro header:
  - Go = 2'b00: load.
  - Stall = 2'b01: hold.
  - Bubble = 2'b10: clear to zero.
- stl_*, pc_wr_o and pc_target_o are combinational from the current state and inputs. Registers are the state, pend_target, and the two counters.
- Reset (rst low, asynchronous):
  - state = RUN; pend_target = 0; counters = 0.
  - While rst is low: every stl_* = Bubble, pc_wr_o = 0, pc_target_o = 0.
- Load-use hazard, define lu = ex_is_load_i & (ex_rd_i != 0) & ((id_rs1_used_i & id_rs1_i == ex_rd_i) | (id_rs2_used_i & id_rs2_i == ex_rd_i)).
- State RUN, evaluated in priority order; the listed codes apply, all unlisted codes are Go, pc_wr_o = 0 unless stated:
  1. mem_busy_i: PC, IF_ID, ID_EX, EX_MEM = Stall; MEM_WB = Bubble. Any pending jump remains asserted because EX is held.
  2. ex_jump_i & !if_busy_i:
     - pc_wr_o = 1, pc_target_o = ex_target_i.
     - IF_ID = Bubble, ID_EX = Bubble.
     - flush_cnt++.
  3. ex_jump_i & if_busy_i:
     - pend_target <= ex_target_i; next state REDIRECT_WAIT.
     - PC = Stall, IF_ID = Bubble, ID_EX = Bubble.
  4. lu: PC = Stall, IF_ID = Stall, ID_EX = Bubble. The stall lasts exactly one cycle because the load advances to MEM.
  5. if_busy_i: PC = Stall, IF_ID = Bubble.
  6. Otherwise: all Go.
- State REDIRECT_WAIT:
  - ex_jump_i and lu are ignored; ID and EX hold bubbles.
  - mem_busy_i: same codes as RUN rule 1; remain in REDIRECT_WAIT.
  - else if_busy_i: PC = Stall, IF_ID = Bubble, ID_EX = Bubble; remain. The wrong-path fetch is discarded.
  - else:
    - pc_wr_o = 1, pc_target_o = pend_target.
    - IF_ID = Bubble, ID_EX = Bubble.
    - flush_cnt++; next state RUN.
- pc_target_o = 0 whenever pc_wr_o = 0.
- When pc_wr_o = 1, the PC loads the target regardless of stl_pc_o (Go in that cycle).
- Counters:
  - Each counter increments at the dclk edge that closes a cycle satisfying its condition.
  - Both counters saturate at all-ones and never wrap.
- Reset asserted mid-operation aborts REDIRECT_WAIT; pend_target is lost. Intended: the core restarts from the reset vector.

Test Plan:
- Reset then release, all inputs 0 → while rst low all stl_* = 2'b10 and counters 0; after release all stl_* = 2'b00 and pc_wr_o = 0.
- ex_is_load_i = 1, ex_rd_i = 5, id_rs2_i = 5, id_rs2_used_i = 1 for one cycle → stl_pc = 01, stl_if_id = 01, stl_id_ex = 10, others 00; stall_cnt = 1 next cycle. Same stimulus with ex_rd_i = 0 → all 00.
- ex_jump_i = 1, ex_target_i = 32'h0000_0100, if_busy_i = 0 → pc_wr_o = 1, pc_target_o = 32'h100, stl_if_id = stl_id_ex = 10; flush_cnt = 1.
- ex_jump_i with target 32'h200 while if_busy_i = 1 for 3 more cycles:
  - During the wait: state REDIRECT_WAIT, pc_wr_o = 0, stl_if_id = 10.
  - In the cycle if_busy_i drops: pc_wr_o = 1, pc_target_o = 32'h200; then RUN.
- mem_busy_i = 1 for 4 cycles with ex_jump_i = 1 and lu true → each cycle PC/IF_ID/ID_EX/EX_MEM = 01, MEM_WB = 10, no redirect; redirect occurs in the cycle after release; stall_cnt += 4.
- Force stall_cnt to all-ones (CNT_W = 4 build) and hold mem_busy_i → stall_cnt stays 4'hF. rst pulsed low during REDIRECT_WAIT → state RUN, counters 0, no redirect after release.
